// File: rtl/shadow_regfile.sv
// shadow_regfile: byte-wide config register file with a shadow bank and an
// active bank. Writes land in the shadow bank. A commit copies the whole
// shadow bank into the active bank in one step, so downstream consumers never
// see a partially updated multi-byte value.
// The address space also holds a control register and read-only status bytes.
//
// Address map:
//   0 .. NUM_REGS-1                      config bytes (shadowed, read/write)
//   NUM_REGS                             CTRL (bit0 = commit, bit1 = lock)
//   NUM_REGS+1 .. NUM_REGS+NUM_STATUS    status bytes (read-only)
//   above                                invalid
//
// Optional feature macro: REGFILE_WRLOCK_EN
//   When defined, CTRL bit1 acts as a write lock that blocks config writes.
//   When undefined, there is no lock logic and CTRL bit1 reads back as 0.

module shadow_regfile #(
    parameter int NUM_REGS   = 25,
    parameter int NUM_STATUS = 4,
    parameter int ADDR_W     = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_write,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [7:0]              i_wr_byte,
    input  logic                    i_read,
    input  logic [ADDR_W-1:0]       i_rd_addr,
    output logic [7:0]              o_rd_byte,
    output logic                    o_rd_valid,
    input  logic                    i_commit,
    input  logic [NUM_STATUS*8-1:0] i_status_vector,
    output logic [NUM_REGS*8-1:0]   o_reg_vector,
    output logic                    o_dirty,
    output logic                    o_commit_done,
    output logic                    o_err
);

    localparam int unsigned CTRL_ADDR = NUM_REGS;
    localparam int unsigned STAT_LO   = NUM_REGS + 1;
    localparam int unsigned STAT_HI   = NUM_REGS + NUM_STATUS;

    // The config bytes, CTRL and the status bytes must all fit in the address space.
    if (longint'(NUM_REGS + NUM_STATUS + 1) > (longint'(1) << ADDR_W)) begin : g_addr_check
        $error("shadow_regfile: NUM_REGS+NUM_STATUS+1 does not fit in ADDR_W address bits");
    end

    logic [7:0] shadow_q [NUM_REGS];
    logic [7:0] shadow_d [NUM_REGS];
    logic [7:0] active_q [NUM_REGS];
    logic [7:0] active_d [NUM_REGS];
    logic       dirty_q, dirty_d;
    logic       commit_done_q, commit_done_d;
    logic       err_q, err_d;
    logic       wr_err, rd_err;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_byte_q, rd_byte_d;
    logic       commit_req;
    logic       lock;

    int unsigned wr_a;
    int unsigned rd_a;
    logic        wr_is_cfg, wr_is_ctrl;
    logic        rd_is_cfg, rd_is_ctrl, rd_is_stat;
    logic [7:0]  shadow_rd;
    logic [7:0]  status_rd;

    assign wr_a = 32'(i_wr_addr);
    assign rd_a = 32'(i_rd_addr);

    assign wr_is_cfg  = (wr_a < CTRL_ADDR);
    assign wr_is_ctrl = (wr_a == CTRL_ADDR);
    assign rd_is_cfg  = (rd_a < CTRL_ADDR);
    assign rd_is_ctrl = (rd_a == CTRL_ADDR);
    assign rd_is_stat = (rd_a >= STAT_LO) && (rd_a <= STAT_HI);

`ifdef REGFILE_WRLOCK_EN
    logic lock_q, lock_d;

    // Lock follows CTRL bit1 on every CTRL write; nothing else touches it.
    always_comb begin
        lock_d = lock_q;
        if (i_write && wr_is_ctrl) begin
            lock_d = i_wr_byte[1];
        end
    end

    // Lock register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

    // Mux the shadow byte selected by the read address.
    always_comb begin
        shadow_rd = 8'h00;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (rd_a == k) begin
                shadow_rd = shadow_q[k];
            end
        end
    end

    // Mux the status byte selected by the read address; it is sampled with the read.
    always_comb begin
        status_rd = 8'h00;
        for (int unsigned k = 0; k < NUM_STATUS; k++) begin
            if (rd_a == STAT_LO + k) begin
                status_rd = i_status_vector[8*k +: 8];
            end
        end
    end

    // Write decode and commit: the commit copies the shadow bank including this cycle's write.
    always_comb begin
        shadow_d      = shadow_q;
        active_d      = active_q;
        dirty_d       = dirty_q;
        commit_done_d = 1'b0;
        wr_err        = 1'b0;
        commit_req    = i_commit;

        if (i_write) begin
            if (wr_is_cfg) begin
                if (lock) begin
                    wr_err = 1'b1;
                end else begin
                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                        if (wr_a == k) begin
                            shadow_d[k] = i_wr_byte;
                        end
                    end
                    dirty_d = 1'b1;
                end
            end else if (wr_is_ctrl) begin
                if (i_wr_byte[0]) begin
                    commit_req = 1'b1;
                end
            end else begin
                // Status bytes are read-only; anything else is unmapped.
                wr_err = 1'b1;
            end
        end

        if (commit_req) begin
            active_d      = shadow_d;
            dirty_d       = 1'b0;
            commit_done_d = 1'b1;
        end
    end

    // Read path: a simultaneous write wins and the read is dropped.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_byte_d  = 8'h00;
        rd_err     = 1'b0;

        if (i_read && !i_write) begin
            rd_valid_d = 1'b1;
            if (rd_is_cfg) begin
                rd_byte_d = shadow_rd;
            end else if (rd_is_ctrl) begin
                rd_byte_d = {dirty_q, 5'b00000, lock, 1'b0};
            end else if (rd_is_stat) begin
                rd_byte_d = status_rd;
            end else begin
                rd_err = 1'b1;
            end
        end
    end

    // Either a rejected write or an unmapped read raises the error pulse.
    always_comb begin
        err_d = wr_err | rd_err;
    end

    // All state registers; reset clears both banks and drops any pending pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= 8'h00;
                active_q[k] <= 8'h00;
            end
            dirty_q       <= 1'b0;
            commit_done_q <= 1'b0;
            err_q         <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_byte_q     <= 8'h00;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            dirty_q       <= dirty_d;
            commit_done_q <= commit_done_d;
            err_q         <= err_d;
            rd_valid_q    <= rd_valid_d;
            rd_byte_q     <= rd_byte_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_vec
        assign o_reg_vector[8*g +: 8] = active_q[g];
    end

    assign o_rd_byte     = rd_byte_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_dirty       = dirty_q;
    assign o_commit_done = commit_done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_shadow_regfile.sv
// Testbench for shadow_regfile: directed scenarios followed by random traffic,
// all checked against a bank-level reference model.

module tb_shadow_regfile;

    localparam int NR = 25;
    localparam int NS = 4;
    localparam int AW = 8;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_write;
    logic [AW-1:0]     i_wr_addr;
    logic [7:0]        i_wr_byte;
    logic              i_read;
    logic [AW-1:0]     i_rd_addr;
    logic [7:0]        o_rd_byte;
    logic              o_rd_valid;
    logic              i_commit;
    logic [NS*8-1:0]   i_status_vector;
    logic [NR*8-1:0]   o_reg_vector;
    logic              o_dirty;
    logic              o_commit_done;
    logic              o_err;

    always #5 i_clk = ~i_clk;

    shadow_regfile #(.NUM_REGS(NR), .NUM_STATUS(NS), .ADDR_W(AW)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_write         (i_write),
        .i_wr_addr       (i_wr_addr),
        .i_wr_byte       (i_wr_byte),
        .i_read          (i_read),
        .i_rd_addr       (i_rd_addr),
        .o_rd_byte       (o_rd_byte),
        .o_rd_valid      (o_rd_valid),
        .i_commit        (i_commit),
        .i_status_vector (i_status_vector),
        .o_reg_vector    (o_reg_vector),
        .o_dirty         (o_dirty),
        .o_commit_done   (o_commit_done),
        .o_err           (o_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] sh_m [NR];
    logic [7:0] ac_m [NR];
    logic [7:0] st_m [NS];
    logic       dirty_m;
    logic       lock_m;
    logic       exp_valid, exp_err, exp_cd;
    logic [7:0] exp_byte;

    function automatic logic [NR*8-1:0] pack_active();
        logic [NR*8-1:0] v;
        v = '0;
        for (int k = 0; k < NR; k++) v[8*k +: 8] = ac_m[k];
        return v;
    endfunction

    function automatic logic [7:0] model_read(input int a);
        if (a < NR) return sh_m[a];
        if (a == NR) return {dirty_m, 5'b00000, lock_m, 1'b0};
        if (a <= NR + NS) return st_m[a - NR - 1];
        return 8'h00;
    endfunction

    task automatic apply_status();
        for (int k = 0; k < NS; k++) i_status_vector[8*k +: 8] = st_m[k];
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [NR*8-1:0] obs, input logic [NR*8-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk8({tag, ".rd_valid"},    8'(o_rd_valid),    8'(exp_valid));
        chk8({tag, ".rd_byte"},     o_rd_byte,         exp_byte);
        chk8({tag, ".err"},         8'(o_err),         8'(exp_err));
        chk8({tag, ".dirty"},       8'(o_dirty),       8'(dirty_m));
        chk8({tag, ".commit_done"}, 8'(o_commit_done), 8'(exp_cd));
        chkv({tag, ".reg_vector"},  o_reg_vector,      pack_active());
    endtask

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            sh_m[k] = 8'h00;
            ac_m[k] = 8'h00;
        end
        dirty_m   = 1'b0;
        lock_m    = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_cd    = 1'b0;
        exp_byte  = 8'h00;
    endtask

    // One clock cycle of traffic; predicts the outputs, then checks them after the edge.
    task automatic cyc(input logic w, input int wa, input logic [7:0] wd,
                       input logic r, input int ra, input logic c, input string tag);
        logic commit;
        i_write   = w;
        i_wr_addr = AW'(wa);
        i_wr_byte = wd;
        i_read    = r;
        i_rd_addr = AW'(ra);
        i_commit  = c;
        apply_status();

        exp_valid = r && !w;
        exp_byte  = exp_valid ? model_read(ra) : 8'h00;
        exp_err   = exp_valid && (ra > NR + NS);
        commit    = c;
        if (w) begin
            if (wa < NR) begin
                if (lock_m) exp_err = 1'b1;
                else begin
                    sh_m[wa] = wd;
                    dirty_m  = 1'b1;
                end
            end else if (wa == NR) begin
`ifdef REGFILE_WRLOCK_EN
                lock_m = wd[1];
`endif
                if (wd[0]) commit = 1'b1;
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_cd = commit;
        if (commit) begin
            ac_m    = sh_m;
            dirty_m = 1'b0;
        end

        @(posedge i_clk);
        #1;
        i_write  = 1'b0;
        i_read   = 1'b0;
        i_commit = 1'b0;
        check_all(tag);
    endtask

    // Synchronous reset, with a commit and a write pending to prove they are aborted.
    task automatic do_reset(input string tag);
        i_rst     = 1'b1;
        i_write   = 1'b1;
        i_wr_addr = AW'(1);
        i_wr_byte = 8'hC3;
        i_commit  = 1'b1;
        i_read    = 1'b0;
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        i_write  = 1'b0;
        i_commit = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        i_rst = 1'b1;
        i_write = 1'b0; i_wr_addr = '0; i_wr_byte = '0;
        i_read = 1'b0; i_rd_addr = '0; i_commit = 1'b0;
        for (int k = 0; k < NS; k++) st_m[k] = 8'($urandom_range(1, 255));
        apply_status();

        // 1. Reset, then read the whole valid map
        do_reset("reset");
        for (int a = 0; a <= NR + NS; a++) cyc(0, 0, 8'h00, 1, a, 0, "t1_read");

        // 2. Write stays in shadow until commit
        cyc(1, 3, 8'h12, 0, 0, 0, "t2_write");
        chk8("t2_active_b3_pre", o_reg_vector[31:24], 8'h00);
        chk8("t2_dirty_pre", 8'(o_dirty), 8'h01);
        cyc(0, 0, 8'h00, 1, 3, 0, "t2_read");
        chk8("t2_read_b3", o_rd_byte, 8'h12);
        cyc(0, 0, 8'h00, 0, 0, 1, "t2_commit");
        chk8("t2_active_b3_post", o_reg_vector[31:24], 8'h12);
        chk8("t2_commit_done", 8'(o_commit_done), 8'h01);

        // 3. Write and commit in the same cycle: the write is forwarded
        cyc(1, 5, 8'hAB, 0, 0, 1, "t3_fwd");
        chk8("t3_active_b5", o_reg_vector[47:40], 8'hAB);
        chk8("t3_dirty", 8'(o_dirty), 8'h00);

        // 4. Rejected accesses
        cyc(1, NR + 1, 8'h55, 0, 0, 0, "t4_wr_status");
        chk8("t4_err_status", 8'(o_err), 8'h01);
        cyc(1, 255, 8'h66, 0, 0, 0, "t4_wr_invalid");
        cyc(0, 0, 8'h00, 1, 255, 0, "t4_rd_invalid");
        chk8("t4_rd_invalid_byte", o_rd_byte, 8'h00);
        cyc(0, 0, 8'h00, 1, NR + 1, 0, "t4_rd_status");

        // 5. Read and write together: the read is dropped
        cyc(1, 2, 8'h5A, 1, 2, 0, "t5_both");
        chk8("t5_valid_dropped", 8'(o_rd_valid), 8'h00);
        cyc(0, 0, 8'h00, 1, 2, 0, "t5_read");
        chk8("t5_read_b2", o_rd_byte, 8'h5A);

        // Commit via CTRL, back-to-back commits, write in the commit cycle
        cyc(1, NR, 8'h01, 0, 0, 0, "ctrl_commit");
        cyc(0, 0, 8'h00, 0, 0, 1, "b2b_commit_a");
        cyc(1, 4, 8'h3C, 0, 0, 1, "b2b_commit_b");
        cyc(1, 7, 8'h99, 0, 0, 0, "write_after_commit");
        cyc(0, 0, 8'h00, 1, NR, 0, "ctrl_read");

`ifdef REGFILE_WRLOCK_EN
        // 6. Write lock
        cyc(1, NR, 8'h02, 0, 0, 0, "t6_lock");
        cyc(1, 0, 8'h77, 0, 0, 0, "t6_locked_wr");
        chk8("t6_locked_err", 8'(o_err), 8'h01);
        cyc(0, 0, 8'h00, 1, 0, 0, "t6_locked_rd");
        chk8("t6_locked_rd_b0", o_rd_byte, 8'h00);
        cyc(0, 0, 8'h00, 0, 0, 1, "t6_locked_commit");
        cyc(1, NR, 8'h00, 0, 0, 0, "t6_unlock");
        cyc(1, 0, 8'h77, 0, 0, 0, "t6_unlocked_wr");
        cyc(0, 0, 8'h00, 1, 0, 0, "t6_unlocked_rd");
        chk8("t6_unlocked_rd_b0", o_rd_byte, 8'h77);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic w, r, c;
            int wa, ra;
            logic [7:0] wd;
            if ($urandom_range(0, 63) == 0) st_m[$urandom_range(0, NS - 1)] = 8'($urandom);
            w  = ($urandom_range(0, 99) < 45);
            r  = ($urandom_range(0, 99) < 50);
            c  = ($urandom_range(0, 99) < 8);
            wa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, NR + NS + 2));
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, NR + NS + 2));
            wd = 8'($urandom);
            if (wa == NR && $urandom_range(0, 1) == 0) wd[1] = 1'b0;
            cyc(w, wa, wd, r, ra, c, "rand");
            if (i == 1500) do_reset("mid_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
